// File: rtl/instr_fetch_stage_if.sv
// Instruction memory request/ack bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC sequencing, instruction memory handshake and the IF/ID pipeline register.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | one full cycle after reset release, no request
// S_FETCH  | request outstanding at r_pc, deliver into IF/ID on ack
// S_HOLD   | fetched word parked in the one-entry buffer while decode stalls
// S_DRAIN  | waiting out a request whose data will be discarded
// S_HALTED | sticky halt, only rst_n leaves this state
module instr_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hE000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_stage_if.master        imem,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_redirect_valid,
    input  logic [15:0]                i_redirect_pc,
    input  logic                       i_halt,
    output logic                       o_ifid_valid,
    output logic [15:0]                o_ifid_instr,
    output logic [15:0]                o_ifid_pc,
    output logic [3:0]                 o_opcode,
    output logic                       o_halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t      r_state;
    logic        r_boot;
    logic [15:0] r_pc;
    logic        r_imem_req;
    logic        r_ifid_valid;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic        r_halted;
    logic [15:0] r_buf_instr;
    logic [15:0] r_buf_pc;
    logic [15:0] r_pend_pc;
    logic        r_halt_pend;

    logic        w_ack;
    logic [15:0] w_pc_inc;
    logic        w_bubble;
    logic        w_halt_go;
    logic [15:0] w_drain_tgt;

    // An ack only means something while our own request is up.
    assign w_ack       = imem.imem_ack & r_imem_req;
    assign w_pc_inc    = r_pc + 16'd1;
    assign w_bubble    = i_flush | ~i_stall;
    assign w_halt_go   = i_halt & ~i_redirect_valid;
    assign w_drain_tgt = i_redirect_valid ? i_redirect_pc : r_pend_pc;

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign o_ifid_valid   = r_ifid_valid;
    assign o_ifid_instr   = r_ifid_instr;
    assign o_ifid_pc      = r_ifid_pc;
    assign o_opcode       = r_ifid_instr[15:12];
    assign o_halted       = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_boot       <= 1'b0;
            r_pc         <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 16'h0000;
            r_halted     <= 1'b0;
            r_buf_instr  <= 16'h0000;
            r_buf_pc     <= 16'h0000;
            r_pend_pc    <= 16'h0000;
            r_halt_pend  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_boot) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_boot <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (i_redirect_valid) begin
                        if (w_bubble) begin
                            r_ifid_valid <= 1'b0;
                            r_ifid_instr <= NOP_INSTR;
                        end
                        if (w_ack) begin
                            r_pc <= i_redirect_pc;
                        end else begin
                            r_pend_pc <= i_redirect_pc;
                            r_state   <= S_DRAIN;
                        end
                    end else if (i_halt) begin
                        r_halted     <= 1'b1;
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        if (w_ack) begin
                            r_state    <= S_HALTED;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_halt_pend <= 1'b1;
                        end
                    end else if (i_flush) begin
                        // Without a new target the word at r_pc is still needed: drop it and refetch.
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                    end else if (i_stall) begin
                        if (w_ack) begin
                            r_buf_instr <= imem.imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_pc        <= w_pc_inc;
                            r_state     <= S_HOLD;
                            r_imem_req  <= 1'b0;
                        end
                    end else if (w_ack) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_instr <= imem.imem_rdata;
                        r_ifid_pc    <= r_pc;
                        r_pc         <= w_pc_inc;
                    end else begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                    end
                end

                S_HOLD: begin
                    if (i_redirect_valid) begin
                        if (w_bubble) begin
                            r_ifid_valid <= 1'b0;
                            r_ifid_instr <= NOP_INSTR;
                        end
                        r_pc       <= i_redirect_pc;
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end else if (w_halt_go) begin
                        r_halted     <= 1'b1;
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        r_state      <= S_HALTED;
                    end else if (i_flush) begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        r_pc         <= r_buf_pc;
                        r_state      <= S_FETCH;
                        r_imem_req   <= 1'b1;
                    end else if (!i_stall) begin
                        r_ifid_valid <= 1'b1;
                        r_ifid_instr <= r_buf_instr;
                        r_ifid_pc    <= r_buf_pc;
                        r_state      <= S_FETCH;
                        r_imem_req   <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (r_halt_pend) begin
                        if (w_ack) begin
                            r_state     <= S_HALTED;
                            r_imem_req  <= 1'b0;
                            r_halt_pend <= 1'b0;
                        end
                    end else if (w_halt_go) begin
                        r_halted     <= 1'b1;
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        if (w_ack) begin
                            r_state    <= S_HALTED;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_halt_pend <= 1'b1;
                        end
                    end else begin
                        if (w_bubble) begin
                            r_ifid_valid <= 1'b0;
                            r_ifid_instr <= NOP_INSTR;
                        end
                        if (w_ack) begin
                            r_pc    <= w_drain_tgt;
                            r_state <= S_FETCH;
                        end else if (i_redirect_valid) begin
                            r_pend_pc <= i_redirect_pc;
                        end
                    end
                end

                S_HALTED: begin
                    r_imem_req <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed boundary cases plus a randomized
// stall/latency/redirect run checked against an in-order instruction stream model.
module tb_instr_fetch_stage;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'hE000;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, redir, halt;
    logic [15:0] redir_pc;
    logic        mem_ready;
    logic        ifid_valid, halted;
    logic [15:0] ifid_instr, ifid_pc;
    logic [3:0]  opcode;

    int n_chk = 0;
    int n_err = 0;

    instr_fetch_stage_if bus ();

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'h9E37;
        return m ^ 16'h5A5A;
    endfunction

    // Memory may raise ack spuriously; the DUT must only honour it with a request up.
    assign bus.imem_ack   = mem_ready;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    instr_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (bus),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_redirect_valid (redir),
        .i_redirect_pc    (redir_pc),
        .i_halt           (halt),
        .o_ifid_valid     (ifid_valid),
        .o_ifid_instr     (ifid_instr),
        .o_ifid_pc        (ifid_pc),
        .o_opcode         (opcode),
        .o_halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},    bus.imem_req, 1'b0);
        chk({tag, "_addr"},   bus.imem_addr, RESET_PC);
        chk({tag, "_valid"},  ifid_valid, 1'b0);
        chk({tag, "_instr"},  ifid_instr, NOP_INSTR);
        chk({tag, "_pc"},     ifid_pc, 16'h0000);
        chk({tag, "_opcode"}, opcode, 4'hE);
        chk({tag, "_halted"}, halted, 1'b0);
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] pc);
        logic [15:0] w;
        w = mem_word(pc);
        chk({tag, "_pc"},     ifid_pc, pc);
        chk({tag, "_valid"},  ifid_valid, 1'b1);
        chk({tag, "_instr"},  ifid_instr, w);
        chk({tag, "_opcode"}, opcode, w[15:12]);
    endtask

    initial begin
        logic [15:0] exp_pc, prev_addr, tgt;
        logic        prev_wait, s, do_redir;
        int          consumed;

        rst_n = 1'b0; stall = 0; flush = 0; redir = 0; halt = 0; redir_pc = 16'h0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("rst");

        // Boot: IDLE for a full cycle, first request on the second edge.
        rst_n = 1'b1;
        step(); chk("boot_idle_req", bus.imem_req, 1'b0);
        step(); chk("boot_req", bus.imem_req, 1'b1); chk("boot_addr", bus.imem_addr, RESET_PC);

        for (int k = 0; k < 4; k++) begin
            step(); chk_ifid("stream", 16'(k));
        end
        step(); chk_ifid("pre_stall", 16'd4); chk("pre_stall_addr", bus.imem_addr, 16'd5);

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_ifid("stall_hold", 16'd4); chk("stall_req", bus.imem_req, 1'b0);
        end
        stall = 1'b0;
        step(); chk_ifid("unstall", 16'd5); chk("unstall_addr", bus.imem_addr, 16'd6);
        step(); chk_ifid("unstall_next", 16'd6);

        // Slow memory, redirect+flush while the request is still open.
        mem_ready = 1'b0;
        step(); chk("wait_addr", bus.imem_addr, 16'd7); chk("wait_valid", ifid_valid, 1'b0);
        redir = 1'b1; redir_pc = 16'h0040; flush = 1'b1;
        step(); chk("drain_req", bus.imem_req, 1'b1); chk("drain_addr", bus.imem_addr, 16'd7);
        chk("drain_valid", ifid_valid, 1'b0);
        redir = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        step(); chk("redir_addr", bus.imem_addr, 16'h0040); chk("stale_valid", ifid_valid, 1'b0);
        chk("stale_instr", ifid_instr, NOP_INSTR);
        step(); chk_ifid("redir_first", 16'h0040);

        // Halt squashed by a same-cycle redirect; also walks the PC across the wrap.
        halt = 1'b1; redir = 1'b1; flush = 1'b1; redir_pc = 16'hFFFE;
        step(); chk("squash_halted", halted, 1'b0); chk("squash_addr", bus.imem_addr, 16'hFFFE);
        halt = 1'b0; redir = 1'b0; flush = 1'b0;
        step(); chk_ifid("wrap_a", 16'hFFFE);
        step(); chk_ifid("wrap_b", 16'hFFFF); chk("wrap_addr", bus.imem_addr, 16'h0000);
        step(); chk_ifid("wrap_c", 16'h0000);

        redir = 1'b1; flush = 1'b1; redir_pc = 16'd5;
        step();
        redir = 1'b0; flush = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            step(); chk_ifid("to_halt", 16'(k));
        end
        halt = 1'b1;
        step(); chk("halt_set", halted, 1'b1); chk("halt_req", bus.imem_req, 1'b0);
        chk("halt_valid", ifid_valid, 1'b0); chk("halt_instr", ifid_instr, NOP_INSTR);
        for (int k = 0; k < 20; k++) begin
            stall = 1'($urandom); flush = 1'($urandom); redir = 1'($urandom);
            halt = 1'($urandom); redir_pc = 16'($urandom); mem_ready = 1'($urandom);
            step(); chk("halted_quiet", {bus.imem_req, halted, ifid_valid}, 3'b010);
        end
        stall = 0; flush = 0; redir = 0; halt = 0; mem_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1 chk_reset("rst_halted");
        @(negedge clk) rst_n = 1'b1;
        step(); step(); chk("mid_req", bus.imem_req, 1'b1);
        step(); chk("mid_req_open", bus.imem_req, 1'b1); chk("mid_addr", bus.imem_addr, RESET_PC);
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_midreq");

        // Randomized run: every instruction decode consumes must be the next in program order.
        @(negedge clk) rst_n = 1'b1;
        exp_pc = RESET_PC; consumed = 0; prev_wait = 1'b0; prev_addr = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_wait) begin
                chk("addr_hold", bus.imem_addr, prev_addr);
                chk("req_hold", bus.imem_req, 1'b1);
            end
            s        = ($urandom_range(0, 9) < 3);
            do_redir = (cyc > 3) && ($urandom_range(0, 24) == 0);
            tgt      = 16'($urandom);
            if (do_redir) begin
                exp_pc = tgt;
            end else if (!s && ifid_valid) begin
                chk_ifid("rand", exp_pc);
                exp_pc = exp_pc + 16'd1;
                consumed++;
            end
            prev_wait = bus.imem_req && !mem_ready;
            prev_addr = bus.imem_addr;
            mem_ready = ($urandom_range(0, 9) < 7);
            prev_wait = bus.imem_req && !mem_ready && !do_redir;
            stall = s; flush = do_redir; redir = do_redir; redir_pc = tgt;
            step();
        end
        chk("progress", consumed > 500, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'hE000, bubble word (opcode 4'b1110, no-op).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port stall, input, 1, hold PC and IF/ID contents.
REQ-006 The block SHALL have port flush, input, 1, replace IF/ID contents with a bubble.
REQ-007 The block SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 16), taken branch/jump target.
REQ-008 The block SHALL have port halt, input, 1, decode-stage halt from the control unit.
REQ-009 The block SHALL have ports imem_req (output, 1), imem_addr (output, 16), imem_ack (input, 1), imem_rdata (input, 16), instruction memory request/ack.
REQ-010 The block SHALL have ports ifid_valid (output, 1), ifid_instr (output, 16), ifid_pc (output, 16), IF/ID register.
REQ-011 The block SHALL have port opcode, output, 4, equal to ifid_instr[15:12] combinationally.
REQ-012 The block SHALL have port halted, output, 1, sticky halt indication.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, HOLD, DRAIN, HALTED; IDLE goes to FETCH unconditionally after one cycle.
REQ-014 imem_req SHALL be registered, be 1 exactly in FETCH and DRAIN, and keep imem_addr = pc constant until imem_ack is sampled high.
REQ-015 In FETCH with imem_ack=1, no stall, no flush, no redirect: IF/ID <= {1, imem_rdata, pc}, pc <= pc+1, stay in FETCH (one instruction per cycle for single-cycle ack).
REQ-016 In FETCH with imem_ack=1 and stall=1: store imem_rdata/pc in a one-entry buffer, pc <= pc+1, IF/ID unchanged, go to HOLD.
REQ-017 In HOLD, imem_req SHALL be 0; when stall=0, IF/ID <= buffer, go to FETCH.
REQ-018 In FETCH, stall=1 with imem_ack=0 SHALL leave the request outstanding and IF/ID unchanged.
REQ-019 flush=1 SHALL load IF/ID with {0, NOP_INSTR, ifid_pc}, SHALL override stall, and SHALL discard any HOLD buffer (next state FETCH).
REQ-020 redirect_valid=1 in FETCH with imem_ack=1 SHALL discard imem_rdata, set pc <= redirect_pc, stay in FETCH.
REQ-021 redirect_valid=1 in FETCH with imem_ack=0 SHALL latch redirect_pc into a pending register and go to DRAIN.
REQ-022 In DRAIN, imem_ack=1 SHALL discard the data, set pc <= pending target, go to FETCH; a further redirect in DRAIN SHALL overwrite the pending target.
REQ-023 redirect_valid=1 in HOLD SHALL discard the buffer, set pc <= redirect_pc, go to FETCH.
REQ-024 halt=1 with redirect_valid=0 SHALL set halted <= 1, bubble IF/ID, and go to HALTED (via DRAIN-style completion if a request is outstanding, data discarded).
REQ-025 redirect_valid=1 and halt=1 in the same cycle SHALL ignore halt (halt instruction is squashed).
REQ-026 In HALTED, imem_req SHALL be 0, IF/ID SHALL hold the bubble, and all inputs except rst_n SHALL be ignored.
REQ-027 pc+1 SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 While rst_n=0: state IDLE, pc=RESET_PC, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, halted=0, buffer and pending target cleared.
REQ-030 Reset assertion mid-request SHALL abandon the request immediately; first imem_req=1 SHALL appear on the second rising edge after rst_n rises.

Verification
REQ-031 Reset, zero-wait ack, rdata=pc-indexed words -> ifid_pc = 0,1,2,3 on consecutive cycles, ifid_valid=1, opcode = rdata[15:12].
REQ-032 stall=1 for 3 cycles during ack at pc=5 -> IF/ID holds pc 4, imem_req=0 in HOLD, pc 5 word enters IF/ID on first cycle after stall drops, no loss or duplicate.
REQ-033 redirect_valid=1, redirect_pc=16'h0040, flush=1 with ack pending (2-cycle latency) -> DRAIN, stale data discarded, next imem_addr=16'h0040, ifid_valid=0 during the bubble.
REQ-034 halt=1 at ifid_pc=7 -> halted=1 next cycle, imem_req stays 0 for 20 cycles; halt+redirect same cycle -> halted stays 0, fetch resumes at target.
REQ-035 pc=16'hFFFF fetch -> next imem_addr=16'h0000; rst_n pulsed low mid-request -> all outputs at REQ-029 values asynchronously.
